// File: rtl/axi_lite_master_engine.sv
// AXI4-Lite master: turns one CMD_* request into a single AXI-Lite read or write transaction.
// Latency: accept in cycle 0, AW/W or AR in cycle 1, B/R in cycle 2, RSP_VALID in cycle 3 with an always-ready slave.
// Backpressure: CMD_READY is high only when idle; every VALID is held until its handshake; RSP has no backpressure.
module axi_lite_master_engine #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   // command side
   input  logic                          CMD_VALID,
   output logic                          CMD_READY,
   input  logic                          CMD_WRITE,
   input  logic [AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
   input  logic [AXI_DATA_WIDTH-1:0]     CMD_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
   // response side
   output logic                          RSP_VALID,
   output logic                          RSP_WRITE,
   output logic [AXI_DATA_WIDTH-1:0]     RSP_RDATA,
   output logic [1:0]                    RSP_RESP,
   // write address channel
   output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   // write data channel
   output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   // write response channel
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   // read address channel
   output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   // read data channel
   input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   // Keeps CMD_READY low until the first clock edge after reset is released.
   logic                      started_q, started_d;
   // Per-channel completion flags while in WADDR; AW and W may finish in any order.
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic                      rsp_write_q, rsp_write_d;
   logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;

   logic cmd_acc;
   logic aw_hs;
   logic w_hs;
   logic b_hs;
   logic ar_hs;
   logic r_hs;

   // Channel outputs are decoded straight from registered state so they are stable for the whole cycle.
   assign CMD_READY     = started_q && (state_q == IDLE);
   assign M_AXI_AWVALID = (state_q == WADDR) && !aw_done_q;
   assign M_AXI_WVALID  = (state_q == WADDR) && !w_done_q;
   assign M_AXI_BREADY  = (state_q == WRESP);
   assign M_AXI_ARVALID = (state_q == RADDR);
   assign M_AXI_RREADY  = (state_q == RDATA);

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;

   assign RSP_VALID     = rsp_valid_q;
   assign RSP_WRITE     = rsp_write_q;
   assign RSP_RDATA     = rsp_rdata_q;
   assign RSP_RESP      = rsp_resp_q;

   assign cmd_acc = CMD_VALID && CMD_READY;
   assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
   assign b_hs    = M_AXI_BREADY && M_AXI_BVALID;
   assign ar_hs   = M_AXI_ARVALID && M_AXI_ARREADY;
   assign r_hs    = M_AXI_RREADY && M_AXI_RVALID;

   // Next-state logic: one transaction at a time, back to IDLE on the B or R handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_acc) begin
               state_d = CMD_WRITE ? WADDR : RADDR;
            end
         end
         WADDR: begin
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = WRESP;
            end
         end
         WRESP: begin
            if (b_hs) begin
               state_d = IDLE;
            end
         end
         RADDR: begin
            if (ar_hs) begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            if (r_hs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: capture the command on accept, track AW/W completion, build the response pulse.
   always_comb begin
      started_d   = 1'b1;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      if (cmd_acc) begin
         addr_d    = CMD_ADDR;
         wdata_d   = CMD_WDATA;
         wstrb_d   = CMD_WSTRB;
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end

      if (aw_hs) begin
         aw_done_d = 1'b1;
      end
      if (w_hs) begin
         w_done_d = 1'b1;
      end

      // Error responses are passed through untouched; the engine never retries.
      if (b_hs) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = 1'b1;
         rsp_rdata_d = '0;
         rsp_resp_d  = M_AXI_BRESP;
      end else if (r_hs) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = 1'b0;
         rsp_rdata_d = M_AXI_RDATA;
         rsp_resp_d  = M_AXI_RRESP;
      end
   end

   // State register; reset aborts any transaction in flight without a response.
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         started_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         started_q   <= started_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Bench for axi_lite_master_engine: 4-word AXI-Lite slave model with programmable ready delays and responses.
// Command vectors come from a table; reset and back-to-back command cases are written out by hand.
// A protocol monitor checks VALID hold, payload stability and VALID drop after each handshake.
`timescale 1ns/1ps
module tb_axi_lite_master_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   axi_lite_master_engine #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
      .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
      .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
      .RSP_VALID(rsp_valid), .RSP_WRITE(rsp_write), .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // ---------------- slave model (acts at the falling edge) ----------------
   logic [31:0] mem [4];
   int          cfg_aw_dly = 0;
   int          cfg_w_dly  = 0;
   logic [1:0]  cfg_bresp  = 2'b00;
   logic [1:0]  cfg_rresp  = 2'b00;
   int          aw_wait, w_wait, idx;
   logic        aw_got, w_got, ar_got;
   logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;

   initial begin
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0; idx = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
         end else begin
            // handshakes decided at the previous falling edge completed at the rising edge in between
            if (hs_aw) aw_got = 1;
            if (hs_w)  w_got  = 1;
            if (hs_ar) ar_got = 1;
            if (hs_b)  bvalid = 0;
            if (hs_r)  rvalid = 0;
            if (aw_got && w_got && !bvalid) begin
               if (cfg_bresp == 2'b00) begin
                  idx = int'(s_awaddr[3:2]);
                  for (int b = 0; b < 4; b++)
                     if (s_wstrb[b]) mem[idx][8*b +: 8] = s_wdata[8*b +: 8];
               end
               bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0;
            end
            if (ar_got && !rvalid) begin
               rvalid = 1; rdata = mem[s_araddr[3:2]]; rresp = cfg_rresp; ar_got = 0;
            end
            if (awvalid) begin
               if (aw_wait >= cfg_aw_dly) awready = 1;
               else begin awready = 0; aw_wait++; end
            end else awready = 0;
            if (wvalid) begin
               if (w_wait >= cfg_w_dly) wready = 1;
               else begin wready = 0; w_wait++; end
            end else wready = 0;
            arready = arvalid;
            hs_aw = awvalid && awready;
            if (hs_aw) begin s_awaddr = awaddr; aw_wait = 0; end
            hs_w = wvalid && wready;
            if (hs_w) begin s_wdata = wdata; s_wstrb = wstrb; w_wait = 0; end
            hs_ar = arvalid && arready;
            if (hs_ar) s_araddr = araddr;
            hs_b = bvalid && bready;
            hs_r = rvalid && rready;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   logic        p_ok = 0;
   logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;
   int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

   always @(negedge clk) begin
      #1;
      if (rst) begin
         p_ok = 0;
      end else begin
         if (p_ok && p_awv && !p_awr) begin
            chk("awvalid_hold", 32'(awvalid), 1);
            chk("awaddr_stable", awaddr, p_awaddr);
         end
         if (p_ok && p_wv && !p_wr) begin
            chk("wvalid_hold", 32'(wvalid), 1);
            chk("wdata_stable", wdata, p_wdata);
            chk("wstrb_stable", 32'(wstrb), 32'(p_wstrb));
         end
         if (p_ok && p_arv && !p_arr) begin
            chk("arvalid_hold", 32'(arvalid), 1);
            chk("araddr_stable", araddr, p_araddr);
         end
         if (p_ok && p_awv && p_awr) chk("awvalid_drop", 32'(awvalid), 0);
         if (p_ok && p_wv && p_wr)   chk("wvalid_drop", 32'(wvalid), 0);
         if (p_ok && p_arv && p_arr) chk("arvalid_drop", 32'(arvalid), 0);
         if (awvalid || arvalid) chk("prot_zero", 32'({awprot, arprot}), 0);
         if (awvalid && awready) n_aw++;
         if (wvalid && wready)   n_w++;
         if (bvalid && bready)   n_b++;
         if (arvalid && arready) n_ar++;
         if (rvalid && rready)   n_r++;
         p_ok = 1;
         p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
         p_arv = arvalid; p_arr = arready;
         p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_ctl"}, 32'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write}), 0);
      chk({name, "_rsp"}, rsp_rdata | 32'(rsp_resp), 0);
      chk({name, "_addr"}, awaddr | araddr, 0);
      chk({name, "_wdat"}, wdata | 32'(wstrb), 0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_dly;
      int          w_dly;
      logic [1:0]  bresp;
      logic [1:0]  rresp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   function automatic vec_t mkv(bit wr, logic [31:0] addr, logic [31:0] wd, logic [3:0] st,
                                int awd, int wdl, logic [1:0] br, logic [1:0] rr,
                                logic [31:0] erd, logic [1:0] ers, int lat);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wd; v.wstrb = st; v.aw_dly = awd; v.w_dly = wdl;
      v.bresp = br; v.rresp = rr; v.exp_rdata = erd; v.exp_resp = ers; v.exp_lat = lat;
      return v;
   endfunction

   // One complete command: accept, scramble inputs after accept, wait for the pulse, check it.
   task automatic do_cmd(input vec_t v, input string name);
      int cyc;
      int a0, w0, b0, ar0, r0;
      cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly; cfg_bresp = v.bresp; cfg_rresp = v.rresp;
      step();
      cyc = 0;
      while (!cmd_ready && cyc < 50) begin step(); cyc++; end
      chk({name, "_cmd_ready"}, 32'(cmd_ready), 1);
      a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
      cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      step();
      cmd_valid = 0; cmd_addr = v.addr ^ 32'h4; cmd_wdata = ~v.wdata; cmd_wstrb = ~v.wstrb;
      cyc = 1;
      while (!rsp_valid && cyc < 100) begin step(); cyc++; end
      chk({name, "_latency"}, cyc, v.exp_lat);
      chk({name, "_rsp_valid"}, 32'(rsp_valid), 1);
      chk({name, "_rsp_write"}, 32'(rsp_write), 32'(v.wr));
      chk({name, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
      chk({name, "_rsp_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
      chk({name, "_idle_at_rsp"}, 32'(cmd_ready), 1);
      step();
      chk({name, "_rsp_pulse_end"}, 32'(rsp_valid), 0);
      chk({name, "_rdata_hold"}, rsp_rdata, v.exp_rdata);
      chk({name, "_resp_hold"}, 32'(rsp_resp), 32'(v.exp_resp));
      chk({name, "_hs_count"}, 32'(((n_aw - a0) << 16) | ((n_w - w0) << 12) | ((n_b - b0) << 8) |
                                    ((n_ar - ar0) << 4) | (n_r - r0)),
          v.wr ? 32'h0001_1100 : 32'h0000_0011);
   endtask

   // ---------------- main sequence ----------------
   vec_t vecs[16];
   int   cyc;

   initial begin
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;

      //                wr  addr   wdata          strb  aw w  bresp  rresp  exp_rdata      resp   lat
      vecs[0]  = mkv(1, 32'h0, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3);
      vecs[1]  = mkv(1, 32'h4, 32'hBAADF00D, 4'hF, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3);
      vecs[2]  = mkv(1, 32'h8, 32'hFEEDFACE, 4'hF, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3);
      vecs[3]  = mkv(1, 32'hC, 32'h0BADC0DE, 4'hF, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3);
      vecs[4]  = mkv(0, 32'h0, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF,  2'b00, 3);
      vecs[5]  = mkv(0, 32'h4, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'hBAADF00D,  2'b00, 3);
      vecs[6]  = mkv(0, 32'h8, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'hFEEDFACE,  2'b00, 3);
      vecs[7]  = mkv(0, 32'hC, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'h0BADC0DE,  2'b00, 3);
      vecs[8]  = mkv(1, 32'h4, 32'h11112222, 4'hF, 0, 3, 2'b00, 2'b00, 32'h0,         2'b00, 6);
      vecs[9]  = mkv(1, 32'h8, 32'h33334444, 4'hF, 3, 0, 2'b00, 2'b00, 32'h0,         2'b00, 6);
      vecs[10] = mkv(1, 32'hC, 32'h55556666, 4'hF, 2, 2, 2'b00, 2'b00, 32'h0,         2'b00, 5);
      vecs[11] = mkv(0, 32'h4, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'h11112222,  2'b00, 3);
      vecs[12] = mkv(0, 32'hC, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'h55556666,  2'b00, 3);
      vecs[13] = mkv(1, 32'h0, 32'h99999999, 4'hF, 0, 0, 2'b10, 2'b00, 32'h0,         2'b10, 3);
      vecs[14] = mkv(0, 32'h0, 32'h0,        4'h0, 0, 0, 2'b00, 2'b11, 32'hDEADBEEF,  2'b11, 3);
      vecs[15] = mkv(0, 32'h0, 32'h0,        4'h0, 0, 0, 2'b00, 2'b00, 32'hDEADBEEF,  2'b00, 3);

      // reset state and first edge after release
      rst = 1;
      repeat (3) step();
      chk_reset_outputs("reset");
      rst = 0;
      #1 chk("ready_before_edge", 32'(cmd_ready), 0);
      @(posedge clk); #1;
      chk("ready_after_edge", 32'(cmd_ready), 1);

      for (int i = 0; i < 16; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));

      // CMD_VALID held through a busy write; second command only accepted in the RSP cycle
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_bresp = 0; cfg_rresp = 0;
      step();
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'hAAAAAAAA; cmd_wstrb = 4'hF;
      step();
      cmd_wdata = 32'h12345678; cmd_wstrb = 4'b0011;
      cyc = 1;
      while (!rsp_valid && cyc < 50) begin
         chk("busy_not_ready", 32'(cmd_ready), 0);
         step(); cyc++;
      end
      chk("held_first_rsp", 32'(rsp_valid), 1);
      chk("held_ready_in_rsp", 32'(cmd_ready), 1);
      step();
      cmd_valid = 0;
      chk("held_second_accepted", 32'(cmd_ready), 0);
      cyc = 1;
      while (!rsp_valid && cyc < 50) begin step(); cyc++; end
      chk("held_second_latency", cyc, 3);
      chk("held_second_write", 32'(rsp_write), 1);
      do_cmd(mkv(0, 32'h0, 32'h0, 4'h0, 0, 0, 2'b00, 2'b00, 32'hAAAA5678, 2'b00, 3), "strb_read");

      // reset while waiting for B
      step();
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'h77777777; cmd_wstrb = 4'hF;
      step();
      cmd_valid = 0;
      step();
      chk("abort_in_wresp", 32'(bready), 1);
      rst = 1;
      #1 chk_reset_outputs("abort");
      repeat (3) begin
         step();
         chk("abort_no_rsp", 32'(rsp_valid), 0);
      end
      rst = 0;
      #1 chk("abort_ready_before_edge", 32'(cmd_ready), 0);
      @(posedge clk); #1;
      chk("abort_ready_after_edge", 32'(cmd_ready), 1);
      chk("abort_no_rsp_after", 32'(rsp_valid), 0);
      do_cmd(mkv(0, 32'h8, 32'h0, 4'h0, 0, 0, 2'b00, 2'b00, 32'h33334444, 2'b00, 3), "post_reset_read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_lite_master_engine.md
AXI_LITE_MASTER_ENGINE -- requirements
Module: axi_lite_master_engine

Interface
REQ-001 AXI_ADDR_WIDTH, 32, address width of CMD_ADDR and M_AXI_AWADDR/ARADDR.
REQ-002 AXI_DATA_WIDTH, 32, data width; all strobe widths are AXI_DATA_WIDTH/8.
REQ-003 M_AXI_ACLK  in  1  single clock; all state changes on the rising edge.
REQ-004 M_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-005 CMD_VALID  in  1  command request.
REQ-006 CMD_READY  out  1  engine idle, command accepted on CMD_VALID&&CMD_READY.
REQ-007 CMD_WRITE  in  1  1=write, 0=read.
REQ-008 CMD_ADDR  in  AXI_ADDR_WIDTH  byte address.
REQ-009 CMD_WDATA  in  AXI_DATA_WIDTH  write data.
REQ-010 CMD_WSTRB  in  AXI_DATA_WIDTH/8  write byte enables.
REQ-011 RSP_VALID  out  1  one-cycle completion pulse, no backpressure.
REQ-012 RSP_WRITE  out  1  completed command was a write.
REQ-013 RSP_RDATA  out  AXI_DATA_WIDTH  read data (0 for writes).
REQ-014 RSP_RESP  out  2  BRESP or RRESP of the completed command.
REQ-015 M_AXI_AWADDR/AWPROT(3)/AWVALID  out, M_AXI_AWREADY  in  write address channel.
REQ-016 M_AXI_WDATA/WSTRB/WVALID  out, M_AXI_WREADY  in  write data channel.
REQ-017 M_AXI_BRESP(2)/BVALID  in, M_AXI_BREADY  out  write response channel.
REQ-018 M_AXI_ARADDR/ARPROT(3)/ARVALID  out, M_AXI_ARREADY  in  read address channel.
REQ-019 M_AXI_RDATA/RRESP(2)/RVALID  in, M_AXI_RREADY  out  read data channel.

Function
REQ-020 FSM states IDLE, WADDR, WRESP, RADDR, RDATA; CMD_READY=1 only in IDLE.
REQ-021 On accept: ADDR/WDATA/WSTRB registered; next state WADDR if CMD_WRITE else RADDR.
REQ-022 WADDR: AWVALID and WVALID both assert the cycle after accept; each drops the cycle after its own handshake; AW and W complete in either order or same cycle.
REQ-023 WADDR->WRESP when both AW and W handshakes done; BREADY=1 only in WRESP.
REQ-024 RADDR: ARVALID asserts the cycle after accept, held until ARREADY; then RDATA with RREADY=1 only in RDATA.
REQ-025 No VALID deasserted before its handshake; AWADDR/WDATA/WSTRB/ARADDR stable while VALID.
REQ-026 B or R handshake -> RSP_VALID=1 for exactly the next cycle with captured RESP/RDATA; FSM in IDLE that cycle (CMD_READY=1).
REQ-027 AWPROT=ARPROT=3'b000 always; SLVERR/DECERR reported unchanged, never retried.
REQ-028 CMD_VALID while CMD_READY=0 ignored; command inputs sampled only at accept.
REQ-029 Minimum latency with always-ready slave replying next cycle: accept cycle 0, AW/W handshake cycle 1, B cycle 2, RSP_VALID cycle 3; read identical.
REQ-030 RSP_RDATA/RSP_RESP hold last value between pulses.

Reset
REQ-031 While M_AXI_ARESET=1 (asynchronous): FSM=IDLE, all VALID/READY outputs and CMD_READY=0, RSP_*=0, registered addr/data=0.
REQ-032 First rising edge after deassertion: CMD_READY=1.
REQ-033 Reset mid-transaction aborts immediately; no RSP_VALID issued for the aborted command.

Verification
REQ-034 Writes DEADBEEF, BAADF00D, FEEDFACE, 0BADC0DE to 0x0/0x4/0x8/0xC, WSTRB=F, to axi_lite_template_slave -> four RSP_VALID pulses, RSP_WRITE=1, RSP_RESP=0.
REQ-035 Reads of 0x0..0xC -> RSP_RDATA equals written words in order, RSP_RESP=0.
REQ-036 Slave model: AWREADY 3 cycles before WREADY, then reversed, then simultaneous -> each VALID held until own handshake, single B accepted, one RSP pulse.
REQ-037 Slave returns BRESP=2'b10 / RRESP=2'b11 -> RSP_RESP=2'b10 / 2'b11, no retry, FSM returns IDLE.
REQ-038 CMD_VALID held high during busy write -> second command accepted only the cycle RSP_VALID=1; CMD_WSTRB=4'b0011 write of 12345678 over AAAAAAAA reads back AAAA5678.
REQ-039 Reset asserted while in WRESP -> all outputs 0 same cycle, no RSP_VALID, CMD_READY=1 one edge after release, next read completes normally.
